// File: rtl/smi_tx_pkg.sv
// Shared constants and types for the SMI TX path: I/Q sync fields, idle sync word,
// serializer state encoding and the default frame width.
package smi_tx_pkg;

    localparam int unsigned WORD_W_DEFAULT = 32;

    localparam logic [1:0]  I_SYNC    = 2'b10;
    localparam logic [1:0]  Q_SYNC    = 2'b01;
    localparam logic [31:0] SYNC_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } state_t;

endpackage

// File: rtl/smi_tx_word_check.sv
// Combinational I/Q frame validator: passes well-formed words (or the all-zero idle word)
// and substitutes the sync word for anything malformed.
module smi_tx_word_check
    import smi_tx_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] checked,
    output logic              bad
);

    localparam logic [WORD_W-1:0] IDLE_WORD = WORD_W'(SYNC_WORD);

    always_comb begin
        bad = 1'b0;
        if (word != IDLE_WORD) begin
            bad = !((word[WORD_W-1 -: 2] == I_SYNC) &&
                    (word[WORD_W/2-1 -: 2] == Q_SYNC) &&
                    !word[0]);
        end
        checked = bad ? IDLE_WORD : word;
    end

endmodule

// File: rtl/smi_tx_serializer.sv
// Gapless MSB-first serializer between the SMI TX FIFO and the modem output register.
// `SMI_TX_TEST_PATTERN_EN adds i_test_mode, which replaces FIFO pops with an internal frame counter.
module smi_tx_serializer
    import smi_tx_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_enable,
`ifdef SMI_TX_TEST_PATTERN_EN
    input  logic              i_test_mode,
`endif
    input  logic              i_fifo_empty,
    output logic              o_fifo_pull,
    input  logic [WORD_W-1:0] i_fifo_data,
    output logic              o_tx_data,
    output logic              o_tx_active,
    output logic              o_frame_start,
    output logic [CNT_W-1:0]  o_sync_err_cnt,
    output logic [CNT_W-1:0]  o_underrun_cnt,
    input  logic              i_clr_cnt
);

    localparam int unsigned      BIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    state_t            state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n, hold, hold_n;
    logic              hold_vld, hold_vld_n;
    logic [BIT_W-1:0]  bitcnt, bitcnt_n;
    logic              pull_q, pull_n, data_due;
    logic              tx_data_n, active_n, fstart_n;
    logic              err_inc, und_inc;
    logic              src_ready, pull_gate;
    logic [WORD_W-1:0] src_word, chk_word;
    logic              chk_bad;

`ifdef SMI_TX_TEST_PATTERN_EN
    logic        pat_sel, pat_due;
    logic [12:0] pat_cnt;

    assign src_ready = i_test_mode || !i_fifo_empty;
    assign pull_gate = !i_test_mode;
    assign src_word  = pat_due ? WORD_W'({I_SYNC, pat_cnt, 1'b0, Q_SYNC, ~pat_cnt, 1'b0})
                               : i_fifo_data;

    // Source selection travels with the pull so it lines up with the read-latency slot.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            pat_sel <= 1'b0;
            pat_due <= 1'b0;
            pat_cnt <= '0;
        end else begin
            if (pull_n) pat_sel <= i_test_mode;
            pat_due <= pull_q && pat_sel;
            if (pat_due) pat_cnt <= pat_cnt + 13'd1;
        end
    end
`else
    assign src_ready = !i_fifo_empty;
    assign pull_gate = 1'b1;
    assign src_word  = i_fifo_data;
`endif

    smi_tx_word_check #(.WORD_W(WORD_W)) u_check (
        .word    (src_word),
        .checked (chk_word),
        .bad     (chk_bad)
    );

    // bitcnt is the index of the bit currently on o_tx_data.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        hold_n     = hold;
        hold_vld_n = hold_vld;
        bitcnt_n   = bitcnt;
        pull_n     = 1'b0;
        tx_data_n  = 1'b0;
        active_n   = 1'b0;
        fstart_n   = 1'b0;
        err_inc    = 1'b0;
        und_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable && src_ready) begin
                    pull_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (data_due) begin
                    tx_data_n = chk_word[WORD_W-1];
                    shreg_n   = {chk_word[WORD_W-2:0], 1'b0};
                    bitcnt_n  = LAST_BIT;
                    active_n  = 1'b1;
                    fstart_n  = 1'b1;
                    err_inc   = chk_bad;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                tx_data_n = shreg[WORD_W-1];
                shreg_n   = {shreg[WORD_W-2:0], 1'b0};
                bitcnt_n  = bitcnt - BIT_W'(1);
                active_n  = 1'b1;
                if (bitcnt == BIT_W'(3) && i_enable && src_ready) pull_n = 1'b1;
                if (bitcnt == BIT_W'(1) && data_due) begin
                    hold_n     = chk_word;
                    hold_vld_n = 1'b1;
                    err_inc    = chk_bad;
                end
                if (bitcnt == '0) begin
                    if (hold_vld) begin
                        tx_data_n  = hold[WORD_W-1];
                        shreg_n    = {hold[WORD_W-2:0], 1'b0};
                        bitcnt_n   = LAST_BIT;
                        fstart_n   = 1'b1;
                        hold_vld_n = 1'b0;
                    end else if (i_enable) begin
                        tx_data_n = 1'b0;
                        shreg_n   = '0;
                        bitcnt_n  = LAST_BIT;
                        fstart_n  = 1'b1;
                        und_inc   = 1'b1;
                    end else begin
                        tx_data_n = 1'b0;
                        active_n  = 1'b0;
                        shreg_n   = '0;
                        bitcnt_n  = '0;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            shreg          <= '0;
            hold           <= '0;
            hold_vld       <= 1'b0;
            bitcnt         <= '0;
            pull_q         <= 1'b0;
            data_due       <= 1'b0;
            o_fifo_pull    <= 1'b0;
            o_tx_data      <= 1'b0;
            o_tx_active    <= 1'b0;
            o_frame_start  <= 1'b0;
            o_sync_err_cnt <= '0;
            o_underrun_cnt <= '0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            hold          <= hold_n;
            hold_vld      <= hold_vld_n;
            bitcnt        <= bitcnt_n;
            pull_q        <= pull_n;
            data_due      <= pull_q;
            o_fifo_pull   <= pull_n && pull_gate;
            o_tx_data     <= tx_data_n;
            o_tx_active   <= active_n;
            o_frame_start <= fstart_n;
            if (i_clr_cnt) o_sync_err_cnt <= '0;
            else if (err_inc && o_sync_err_cnt != '1) o_sync_err_cnt <= o_sync_err_cnt + 1'b1;
            if (i_clr_cnt) o_underrun_cnt <= '0;
            else if (und_inc && o_underrun_cnt != '1) o_underrun_cnt <= o_underrun_cnt + 1'b1;
        end
    end

endmodule
